// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_pkg
// Shared definitions for the 5-stage pipeline sequencing controller:
//   state_e   - controller state (RUN, LSTALL, STEP)
//   REG_ZERO  - architectural $zero register index (never a real dependency)
//   strobe_t  - the five pipeline-register load enables plus the two bubble
//               clears, bundled so a whole cycle's behaviour is one value
//   STRB_*    - the strobe patterns the controller can emit
// -----------------------------------------------------------------------------
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        STEP   = 2'd2
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_le;
        logic if_id_le;
        logic id_ex_le;
        logic ex_mem_le;
        logic mem_wb_le;
        logic if_id_clear;
        logic id_ex_clear;
    } strobe_t;

    // Normal flow: every register advances, nothing is squashed.
    localparam strobe_t STRB_RUN   = 7'b11111_00;
    // Taken branch: fetched instruction behind the branch becomes a bubble.
    localparam strobe_t STRB_FLUSH = 7'b11111_10;
    // Load-use stall: PC and IF/ID hold, a bubble enters EX, the load and
    // everything ahead of it keep draining.
    localparam strobe_t STRB_STALL = 7'b00111_01;
    // Full freeze (memory wait or single-step hold).
    localparam strobe_t STRB_HOLD  = 7'b00000_00;
    // While in reset the front of the pipe is held empty.
    localparam strobe_t STRB_RESET = 7'b00000_11;

endpackage

// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
// Bundles the pipeline-facing signals of hazard_ctrl.
//   slave  : the controller (consumes ID/EX fields and status, drives strobes)
//   master : the pipeline / environment side
// Inputs to the controller:
//   id_rs, id_rt, id_uses_rt  - source operands of the instruction in ID
//   ex_rt, ex_memtoreg        - destination/load flag of the instruction in EX
//   branch_taken              - branch/jump resolved taken in ID
//   mem_busy                  - data memory not ready, freeze everything
//   step_mode, step_req       - debug single-step enable and advance pulse
//   cnt_clr                   - clear the stall counter
// Outputs from the controller:
//   pc_le .. mem_wb_le        - pipeline register load enables
//   if_id_clear, id_ex_clear  - bubble injection
//   stall_cnt                 - saturating stalled-cycle count
//   busy                      - controller not in RUN
// -----------------------------------------------------------------------------
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic [4:0]       ex_rt;
    logic             ex_memtoreg;
    logic             branch_taken;
    logic             mem_busy;
    logic             step_mode;
    logic             step_req;
    logic             cnt_clr;

    logic             pc_le;
    logic             if_id_le;
    logic             id_ex_le;
    logic             ex_mem_le;
    logic             mem_wb_le;
    logic             if_id_clear;
    logic             id_ex_clear;
    logic [CNT_W-1:0] stall_cnt;
    logic             busy;

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_rt, ex_memtoreg,
        input  branch_taken, mem_busy, step_mode, step_req, cnt_clr,
        output pc_le, if_id_le, id_ex_le, ex_mem_le, mem_wb_le,
        output if_id_clear, id_ex_clear, stall_cnt, busy
    );

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_rt, ex_memtoreg,
        output branch_taken, mem_busy, step_mode, step_req, cnt_clr,
        input  pc_le, if_id_le, id_ex_le, ex_mem_le, mem_wb_le,
        input  if_id_clear, id_ex_clear, stall_cnt, busy
    );

endinterface

// File: rtl/hazard_ctrl_hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Purely combinational load-use comparator. Flags a hazard when the
// instruction in EX is a load whose destination (rt) is a non-zero register
// that the instruction in ID reads as rs, or as rt when ID actually uses rt.
// Ports:
//   id_rs_i, id_rt_i   - source fields of the ID instruction
//   id_uses_rt_i       - ID instruction reads rt
//   ex_rt_i            - load destination held in ID/EX
//   ex_memtoreg_i      - EX instruction is a load
//   hazard_o           - load-use dependency present this cycle
// -----------------------------------------------------------------------------
module hazard_detect
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_uses_rt_i,
    input  logic [4:0] ex_rt_i,
    input  logic       ex_memtoreg_i,
    output logic       hazard_o
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (ex_rt_i == id_rs_i);
    // rt only matters for instructions that read it (R-type, store, beq/bne);
    // for I-type ALU/loads rt is a destination and cannot create a dependency.
    assign rt_match = id_uses_rt_i && (ex_rt_i == id_rt_i);

    // Writes to $zero are discarded, so a load into $zero never stalls.
    assign hazard_o = ex_memtoreg_i && (ex_rt_i != REG_ZERO) && (rs_match || rt_match);

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline sequencing controller for the 5-stage MIPS core. Generates the
// load enables and bubble clears for PC, IF/ID, ID/EX, EX/MEM and MEM/WB,
// covering load-use stalls (LOAD_STALL_CYCLES bubbles), taken-branch flushes,
// data-memory wait freezes and debug single-step. Also keeps a saturating
// count of stalled cycles.
// Parameters:
//   LOAD_STALL_CYCLES - bubbles per load-use hazard (1..7)
//   CNT_W             - stall counter width (must match the interface)
// Ports:
//   clk    - system clock
//   reset  - synchronous, active-high reset
//   bus    - hazard_ctrl_if.slave, all pipeline-facing signals
// All strobes are combinational from state and inputs; the pipeline registers
// sample them on the next clk edge.
// -----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
)
(
    input  logic           clk,
    input  logic           reset,
    hazard_ctrl_if.slave   bus
);

    // Value loaded into rem on entering LSTALL: the hazard cycle itself
    // already counts as the first bubble.
    localparam logic [2:0] REM_LOAD = 3'(LOAD_STALL_CYCLES - 1);

    state_e           state_q, state_d;
    logic [2:0]       rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             hazard;
    logic             run_eval;
    logic             stall_inc;
    strobe_t          strb_fsm;
    strobe_t          strb;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    hazard_detect u_hazard_detect (
        .id_rs_i       (bus.id_rs),
        .id_rt_i       (bus.id_rt),
        .id_uses_rt_i  (bus.id_uses_rt),
        .ex_rt_i       (bus.ex_rt),
        .ex_memtoreg_i (bus.ex_memtoreg),
        .hazard_o      (hazard)
    );

    // Next-state and strobe decode.
    // run_eval marks cycles that behave as ordinary RUN: RUN itself, and a
    // STEP cycle released by step_req.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        strb_fsm  = STRB_RUN;
        stall_inc = 1'b0;
        run_eval  = 1'b0;

        if (bus.mem_busy) begin
            // Freeze outranks everything: state and rem are untouched, so an
            // in-progress load stall is stretched rather than consumed.
            strb_fsm  = STRB_HOLD;
            stall_inc = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (bus.step_mode && !bus.step_req) begin
                        strb_fsm = STRB_HOLD;
                        state_d  = STEP;
                    end else begin
                        run_eval = 1'b1;
                    end
                end
                LSTALL: begin
                    strb_fsm  = STRB_STALL;
                    stall_inc = 1'b1;
                    if (rem_q <= 3'd1) begin
                        rem_d   = 3'd0;
                        state_d = bus.step_mode ? STEP : RUN;
                    end else begin
                        rem_d = rem_q - 3'd1;
                    end
                end
                STEP: begin
                    if (!bus.step_mode) begin
                        strb_fsm = STRB_HOLD;
                        state_d  = RUN;
                    end else if (bus.step_req) begin
                        run_eval = 1'b1;
                    end else begin
                        strb_fsm = STRB_HOLD;
                    end
                end
                default: begin
                    strb_fsm = STRB_HOLD;
                    state_d  = RUN;
                end
            endcase

            if (run_eval) begin
                // A branch seen together with a hazard is dropped: its
                // operands are not ready, it re-resolves after the stall.
                if (hazard) begin
                    strb_fsm  = STRB_STALL;
                    stall_inc = 1'b1;
                    if (LOAD_STALL_CYCLES > 1) begin
                        state_d = LSTALL;
                        rem_d   = REM_LOAD;
                    end
                end else if (bus.branch_taken) begin
                    strb_fsm = STRB_FLUSH;
                end
            end
        end
    end

    // Clear wins over a same-cycle increment.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.cnt_clr) begin
            cnt_d = '0;
        end else if (stall_inc) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            rem_q   <= 3'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset forces the front of the pipe empty regardless of stored state,
    // so an aborted stall or step leaves nothing behind.
    assign strb = reset ? STRB_RESET : strb_fsm;

    assign bus.pc_le       = strb.pc_le;
    assign bus.if_id_le    = strb.if_id_le;
    assign bus.id_ex_le    = strb.id_ex_le;
    assign bus.ex_mem_le   = strb.ex_mem_le;
    assign bus.mem_wb_le   = strb.mem_wb_le;
    assign bus.if_id_clear = strb.if_id_clear;
    assign bus.id_ex_clear = strb.id_ex_clear;
    assign bus.stall_cnt   = cnt_q;
    assign bus.busy        = !reset && (state_q != RUN);

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. It generates the load-enable and clear strobes for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, which covers load-use stalls (with a configurable bubble count), taken-branch flushes, data-memory wait freezes and a debug single-step mode. It sits beside the pipeline registers and counts stalled cycles for performance visibility.

## Interface
- LOAD_STALL_CYCLES, 1: bubbles inserted per load-use hazard (1..7)
- CNT_W, 16: width of stall cycle counter
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- id_rs, id_rt  in  5 each  source register fields of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt (R-type, store, beq/bne)
- ex_rt  in  5  rt field held in ID/EX
- ex_memtoreg  in  1  instruction in EX is a load
- branch_taken  in  1  branch/jump resolved taken in ID this cycle
- mem_busy  in  1  data memory not ready; the whole pipe must freeze
- step_mode  in  1  debug single-step enable
- step_req  in  1  one-cycle pulse that advances one step
- cnt_clr  in  1  clear stall counter
- pc_le, if_id_le, id_ex_le, ex_mem_le, mem_wb_le  out  1 each  register load enables
- if_id_clear, id_ex_clear  out  1 each  inject bubble (register loads zero on the edge)
- stall_cnt  out  CNT_W  saturating count of cycles with pc_le=0 (reset and step-hold excluded)
- busy  out  1  state is not RUN

## Operation
- States: RUN, LSTALL, STEP. All strobe outputs are combinational from state and inputs, and they are sampled by the pipeline registers at the next clk edge.
- hazard = ex_memtoreg & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
- Priority from highest to lowest: reset > mem_busy > step hold > hazard > branch_taken.
- mem_busy=1 (any state): all *_le=0 and both clears=0. State, remaining-count and step handling do not change. stall_cnt increments.
- RUN with no hazard and no branch: all le=1 and clears=0.
- RUN with hazard:
  - pc_le=0, if_id_le=0, id_ex_clear=1, other le=1.
  - branch_taken is ignored, because the branch is re-resolved after the stall.
  - If LOAD_STALL_CYCLES>1, go to LSTALL with rem=LOAD_STALL_CYCLES-1. Otherwise stay.
- RUN with branch_taken and no hazard: if_id_clear=1, all le=1.
- LSTALL: same outputs as the hazard cycle, with id_ex_clear=1 every cycle. Decrement rem each cycle; when rem reaches 1, return to RUN or STEP according to step_mode. LSTALL ignores step_mode and step_req and completes on its own.
- Entering STEP: RUN with step_mode=1 and step_req=0 goes to STEP. The entry cycle is a hold cycle.
- STEP without step_req: all le=0 and clears=0 (full hold).
- STEP with step_req=1 (and mem_busy=0): evaluate exactly as RUN for that cycle, including transitions. A hazard goes to LSTALL.
- STEP with step_mode=0: return to RUN. The exit cycle is a hold cycle.
- stall_cnt:
  - Increments when pc_le=0 in RUN/LSTALL or when mem_busy=1, and saturates at all-ones.
  - cnt_clr zeros it. If cnt_clr and an increment happen in the same cycle, the result is 0.

## Timing
- While reset=1: state=RUN, rem=0, stall_cnt=0, all *_le=0, if_id_clear=1, id_ex_clear=1, busy=0. The first cycle after reset is in RUN.
- Reset mid-LSTALL or mid-STEP aborts immediately, and no stall cycles are left pending.
- Hazard reaction is in the same cycle (zero latency). The consuming instruction leaves ID exactly LOAD_STALL_CYCLES cycles later.
- Branch flush costs exactly 1 bubble.
- mem_busy arriving during LSTALL stretches the stall without consuming rem.
- A step_req that arrives while in LSTALL or under mem_busy is dropped and not queued.

## Structure
- The shared pipeline package holds:
  - the state enum (RUN, LSTALL, STEP)
  - the REG_ZERO=5'd0 constant
  - a strobe struct bundling the 5 le signals and 2 clear signals
- One natural sub-module: hazard_detect, a purely combinational load-use comparator that produces `hazard`.
- The FSM, rem counter and stall_cnt live in hazard_ctrl.

## Test plan
- Load-use hazard, N=1: lw $3 in EX with ex_rt=3, id_rs=3 → one cycle with pc_le=0, if_id_le=0, id_ex_clear=1; stall_cnt=1; RUN the next cycle.
- ex_rt=0 with ex_memtoreg=1 and id_rs=0 → no stall, all le=1.
- N=3: hazard → 3 consecutive stall cycles. Assert mem_busy on the 2nd of them for 2 cycles → full freeze. Total stall = 5 cycles and stall_cnt=5.
- Hazard and branch_taken together → stall only, no if_id_clear. On the next cycle branch_taken alone → if_id_clear=1 for 1 cycle.
- step_mode=1 → full hold. Three step_req pulses → exactly 3 cycles with all le=1. step_mode=0 → RUN after one hold cycle.
- Reset asserted in LSTALL with rem=2 → the required reset values, then RUN with no residual stall. stall_cnt at all-ones stays saturated; cnt_clr → 0.
